// File: rtl/nn_layer_sequencer.sv
// ============================================================================
// Module   : nn_layer_sequencer
// Purpose  : Runs NUM_LAYERS back-to-back NN engine passes per frame, handing
//            each pass its src/dst BRAM bases (image -> ping-pong A/B), a
//            START_LEN-cycle start pulse, and a per-layer hang timeout.
// Options  : NN_SEQ_PERF_EN enables the perf_cycles frame cycle counter;
//            without it perf_cycles is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nn_layer_sequencer #(
  parameter int                NUM_LAYERS = 4,
  parameter int                ADDR_W     = 12,
  parameter int                START_LEN  = 6,
  parameter int                TIMEOUT    = 50000,
  parameter logic [ADDR_W-1:0] IMG_BASE   = 'h000,
  parameter logic [ADDR_W-1:0] BUF_A_BASE = 'h800,
  parameter logic [ADDR_W-1:0] BUF_B_BASE = 'hC00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_frame_start,
  input  logic              i_abort,
  input  logic              i_eng_done,
  output logic              o_eng_start,
  output logic [ADDR_W-1:0] o_eng_src_base,
  output logic [ADDR_W-1:0] o_eng_dst_base,
  output logic [3:0]        o_layer_idx,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [ADDR_W-1:0] o_final_base,
  output logic              o_err_timeout,
  output logic [31:0]       o_perf_cycles
);

  localparam int SL_W = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  localparam logic [SL_W-1:0]   C_START_LAST = SL_W'(START_LEN - 1);
  localparam logic [19:0]       C_TO_LAST    = 20'(TIMEOUT - 1);
  localparam logic [3:0]        C_LAST_LAYER = 4'(NUM_LAYERS - 1);
  // Last layer index even -> its output lands in buffer A, otherwise B.
  localparam logic [ADDR_W-1:0] C_FINAL_BASE =
      (((NUM_LAYERS - 1) % 2) == 0) ? BUF_A_BASE : BUF_B_BASE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            r_state;
  logic              r_eng_start;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [3:0]        r_layer;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_err;
  logic              r_done_pend;
  logic [SL_W-1:0]   r_start_cnt;
  logic [19:0]       r_to_cnt;
  logic              w_accept;

  // A frame request counts only in IDLE and only if abort is not also present.
  assign w_accept = (r_state == S_IDLE) && i_frame_start && !i_abort;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_eng_start  <= 1'b0;
      r_src        <= '0;
      r_dst        <= '0;
      r_layer      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_done_pend  <= 1'b0;
      r_start_cnt  <= '0;
      r_to_cnt     <= '0;
    end else if (i_abort) begin
      r_state      <= S_IDLE;
      r_eng_start  <= 1'b0;
      r_src        <= '0;
      r_dst        <= '0;
      r_layer      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_done_pend  <= 1'b0;
      r_start_cnt  <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_frame_start) begin
            r_state <= S_SETUP;
            r_busy  <= 1'b1;
            r_layer <= '0;
            r_err   <= 1'b0;
          end
        end
        S_SETUP: begin
          // Layer N reads what layer N-1 wrote; r_dst still holds that base here.
          r_src       <= (r_layer == 4'd0) ? IMG_BASE : r_dst;
          r_dst       <= r_layer[0] ? BUF_B_BASE : BUF_A_BASE;
          r_done_pend <= 1'b0;
          r_start_cnt <= '0;
          r_eng_start <= 1'b1;
          r_state     <= S_START;
        end
        S_START: begin
          if (i_eng_done) begin
            r_done_pend <= 1'b1;
          end
          if (r_start_cnt == C_START_LAST) begin
            r_eng_start <= 1'b0;
            r_to_cnt    <= '0;
            r_state     <= S_WAIT;
          end else begin
            r_start_cnt <= r_start_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (i_eng_done || r_done_pend) begin
            r_done_pend <= 1'b0;
            r_state     <= S_NEXT;
          end else if (r_to_cnt == C_TO_LAST) begin
            r_state <= S_ERR;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (r_layer == C_LAST_LAYER) begin
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_layer <= r_layer + 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_src   <= '0;
          r_dst   <= '0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_src   <= '0;
          r_dst   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_eng_start    = r_eng_start;
  assign o_eng_src_base = r_src;
  assign o_eng_dst_base = r_dst;
  assign o_layer_idx    = r_layer;
  assign o_busy         = r_busy;
  assign o_frame_done   = r_frame_done;
  assign o_final_base   = C_FINAL_BASE;
  assign o_err_timeout  = r_err;

`ifdef NN_SEQ_PERF_EN
  logic [31:0] r_perf;

  // Counts every busy cycle (DONE/ERR included), then holds once back in IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf <= '0;
    end else if (w_accept) begin
      r_perf <= '0;
    end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign o_perf_cycles = r_perf;
`else
  assign o_perf_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
// ============================================================================
// Module   : tb_nn_layer_sequencer
// Purpose  : Directed scoreboard bench for nn_layer_sequencer (4 layers,
//            START_LEN 6, TIMEOUT 100). Honours NN_SEQ_PERF_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nn_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        abort = 1'b0;
  logic        eng_done = 1'b0;
  logic        eng_start;
  logic [11:0] src_base;
  logic [11:0] dst_base;
  logic [3:0]  layer_idx;
  logic        busy;
  logic        frame_done;
  logic [11:0] final_base;
  logic        err_timeout;
  logic [31:0] perf_cycles;

  nn_layer_sequencer #(
    .NUM_LAYERS(4), .ADDR_W(12), .START_LEN(6), .TIMEOUT(100),
    .IMG_BASE(12'h000), .BUF_A_BASE(12'h800), .BUF_B_BASE(12'hC00)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_frame_start(frame_start),
    .i_abort(abort), .i_eng_done(eng_done), .o_eng_start(eng_start),
    .o_eng_src_base(src_base), .o_eng_dst_base(dst_base),
    .o_layer_idx(layer_idx), .o_busy(busy), .o_frame_done(frame_done),
    .o_final_base(final_base), .o_err_timeout(err_timeout),
    .o_perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [11:0] src;
    logic [11:0] dst;
    logic [3:0]  layer;
  } pass_t;

  pass_t pass_q[$];
  int    done_q[$];
  int    start_cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    eng_mode = 0;   // 0: done 10 cycles after start falls, 1: done held high, 2: never

  logic [11:0] src_tab [4] = '{12'h000, 12'h800, 12'hC00, 12'h800};
  logic [11:0] dst_tab [4] = '{12'h800, 12'hC00, 12'h800, 12'hC00};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int nl, input int lat);
    for (int l = 0; l < nl; l++) begin
      pass_t p;
      p.src   = src_tab[l];
      p.dst   = dst_tab[l];
      p.layer = 4'(l);
      pass_q.push_back(p);
    end
    if (lat >= 0) done_q.push_back(lat);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_busy_low(input int max, input string nm);
    for (int i = 0; i < max && busy; i++) @(negedge clk);
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic wait_layer_start(input int l, input string nm);
    for (int i = 0; i < 400 && !(layer_idx == 4'(l) && eng_start); i++) @(negedge clk);
    chk(nm, 32'(layer_idx == 4'(l) && eng_start), 32'd1);
  endtask

  // Engine model: responds to the start pulse according to eng_mode.
  initial begin
    int   cnt;
    logic pst;
    cnt = 0;
    pst = 1'b0;
    forever begin
      @(negedge clk);
      case (eng_mode)
        0: begin
          eng_done = 1'b0;
          if (pst && !eng_start) cnt = 10;
          else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) eng_done = 1'b1;
          end
        end
        1: begin eng_done = 1'b1; cnt = 0; end
        default: begin eng_done = 1'b0; cnt = 0; end
      endcase
      pst = eng_start;
    end
  end

  // Monitor: pops expectations whenever the DUT starts a pass or finishes a frame.
  initial begin
    logic  prev_st;
    int    width;
    bit    perf_due;
    int    exp_lat;
    pass_t p;
    prev_st  = 1'b0;
    width    = 0;
    perf_due = 1'b0;
    exp_lat  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_st  = 1'b0;
        width    = 0;
        perf_due = 1'b0;
      end else begin
        if (perf_due) begin
          perf_due = 1'b0;
`ifdef NN_SEQ_PERF_EN
          chk("perf_after_done", perf_cycles, 32'(exp_lat));
`else
          chk("perf_tied_zero", perf_cycles, 32'd0);
`endif
        end
        if (eng_start && !prev_st) begin
          width = 0;
          if (pass_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_start: got layer %0d expected none", layer_idx);
          end else begin
            p = pass_q.pop_front();
            chk("pass_src", 32'(src_base), 32'(p.src));
            chk("pass_dst", 32'(dst_base), 32'(p.dst));
            chk("pass_layer", 32'(layer_idx), 32'(p.layer));
          end
        end
        if (eng_start) width++;
        if (!eng_start && prev_st) chk("start_width", 32'(width), 32'd6);
        if (frame_done) begin
          if (done_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame_done: got pulse expected none");
          end else begin
            exp_lat = done_q.pop_front();
            chk("frame_latency", 32'(cyc - start_cyc), 32'(exp_lat));
            perf_due = 1'b1;
          end
        end
        prev_st = eng_start;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_src", 32'(src_base), 32'd0);
    chk("rst_dst", 32'(dst_base), 32'd0);
    chk("rst_layer", 32'(layer_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_perf", perf_cycles, 32'd0);
    chk("final_base", 32'(final_base), 32'hC00);

    // Normal 4-layer frame: 4*(1+6+11+1)+1 = 77 cycles.
    eng_mode = 0;
    push_frame(4, 77);
    pulse_start();
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_busy_low(300, "frame1_end");
    repeat (3) @(negedge clk);
`ifdef NN_SEQ_PERF_EN
    chk("perf_held", perf_cycles, 32'd77);
`else
    chk("perf_held", perf_cycles, 32'd0);
`endif

    // eng_done held high: every WAIT is 1 cycle, 4*(1+6+1+1)+1 = 37.
    eng_mode = 1;
    push_frame(4, 37);
    pulse_start();
    wait_busy_low(300, "pend_end");
    eng_mode = 0;
    repeat (3) @(negedge clk);

    // Hung engine: SETUP + 6 START + 100 WAIT + ERR, idle at +109.
    eng_mode = 2;
    push_frame(1, -1);
    pulse_start();
    wait_busy_low(300, "timeout_end");
    chk("timeout_latency", 32'(cyc - start_cyc), 32'd109);
    chk("timeout_err", 32'(err_timeout), 32'd1);
`ifdef NN_SEQ_PERF_EN
    chk("timeout_perf", perf_cycles, 32'd108);
`else
    chk("timeout_perf", perf_cycles, 32'd0);
`endif
    eng_mode = 0;
    repeat (2) @(negedge clk);
    push_frame(4, 77);
    pulse_start();
    chk("err_cleared", 32'(err_timeout), 32'd0);
    wait_busy_low(300, "recover_end");
    repeat (3) @(negedge clk);

    // Abort in layer 2 WAIT, then restart from layer 0.
    push_frame(3, -1);
    pulse_start();
    wait_layer_start(2, "reach_layer2");
    for (int i = 0; i < 20 && eng_start; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_layer", 32'(layer_idx), 32'd0);
    chk("abort_eng_start", 32'(eng_start), 32'd0);
    repeat (20) @(negedge clk);
    push_frame(4, 77);
    pulse_start();
    wait_busy_low(300, "post_abort_end");
    repeat (3) @(negedge clk);

    // abort and frame_start together in IDLE: stays idle.
    abort = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    frame_start = 1'b0;
    chk("abort_vs_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_vs_start_busy2", 32'(busy), 32'd0);

    // Second frame_start during layer 1 START is ignored.
    push_frame(4, 77);
    pulse_start();
    wait_layer_start(1, "reach_layer1");
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_busy_low(300, "ignore_end");
    repeat (3) @(negedge clk);
    chk("ignore_no_restart", 32'(busy), 32'd0);

    // Reset mid-frame returns to reset values with no frame_done.
    push_frame(1, -1);
    pulse_start();
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_src", 32'(src_base), 32'd0);
    chk("midrst_eng_start", 32'(eng_start), 32'd0);
    repeat (30) @(negedge clk);

    chk("pass_q_empty", 32'(pass_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
